exm_mem_stage: RTL and testbench
================================

EXM_MEM_STAGE -- requirements
Module: exm_mem_stage

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-003 ex_valid  in  1  EX stage presents a valid instruction.
REQ-004 flush  in  1  kill instruction being captured from EX.
REQ-005 MemRead_in, MemWrite_in, MemToReg_in, RegWrite_in  in  1 each  EX control bits.
REQ-006 ALU_Result_in  in  16  EX result; also the data-memory address.
REQ-007 WriteData_in  in  16  store data.
REQ-008 movOP_in  in  4  move-op code, passed through.
REQ-009 IDEX_RS, IDEX_RT  in  4 each  source register numbers, for forwarding.
REQ-010 mem_req  out  1  data-memory request.
REQ-011 mem_we  out  1  1 = write, 0 = read.
REQ-012 mem_addr, mem_wdata  out  16 each  memory address and store data.
REQ-013 mem_rdata  in  16  read data, valid with mem_ack.
REQ-014 mem_ack  in  1  one-cycle access completion.
REQ-015 stall_out  out  1  upstream SHALL hold EX inputs while high.
REQ-016 wb_valid  out  1  outputs below carry a completed instruction.
REQ-017 MemToReg_out, RegWrite_out  out  1 each  to MWBBuffer.
REQ-018 ALU_Result_out, ReadData_out  out  16 each  to MWBBuffer.
REQ-019 movOP_out  out  4  to MWBBuffer.
REQ-020 EXM_RS, EXM_RT  out  4 each  forwarding register numbers.
REQ-021 mem_err  out  1  sticky memory-timeout flag.

Function
REQ-022 Internal EX/MEM register R holds: valid, all control bits, ALU result, write data, movOP, RS, RT. Non-ack outputs are driven from R.
REQ-023 States: ACTIVE and MEMWAIT. A 4-bit wait counter is cleared on every entry to MEMWAIT.
REQ-024 Capture rule: on each edge with stall_out=0, R is loaded from EX inputs.
  - R.valid = ex_valid & ~flush.
  - flush is ignored on edges where stall_out=1.
REQ-025 After a capture, if R.valid & (MemRead|MemWrite), the next state is MEMWAIT; otherwise it is ACTIVE.
REQ-026 ACTIVE behaviour: stall_out=0, mem_req=0, wb_valid=R.valid. A non-memory instruction is therefore presented one cycle after capture.
REQ-027 MEMWAIT behaviour: stall_out=1, wb_valid=0, mem_req=1.
  - mem_we=R.MemWrite, mem_addr=R.ALU_Result, mem_wdata=R.WriteData.
  - R is held.
REQ-028 mem_ack in MEMWAIT moves the state to ACTIVE. ReadData_out <= mem_rdata if R.MemRead, else 16'h0000. The instruction is then presented with wb_valid=1 for exactly one cycle.
REQ-029 mem_ack while in ACTIVE SHALL be ignored.
REQ-030 Timeout: if 15 cycles elapse in MEMWAIT without mem_ack:
  - mem_err <= 1;
  - ReadData_out <= 0;
  - the instruction completes with RegWrite_out forced 0;
  - the state moves to ACTIVE.
REQ-031 If mem_ack and the 15th wait cycle coincide, mem_ack wins and mem_err is unchanged.
REQ-032 RegWrite_out = R.RegWrite & wb_valid (and not timed out). MemToReg_out, ALU_Result_out, movOP_out, EXM_RS and EXM_RT mirror R.
REQ-033 mem_err clears only on reset.
REQ-034 Back-to-back memory operations SHALL each incur MEMWAIT; no access is ever dropped or duplicated.
REQ-035 mem_req SHALL fall in the cycle after mem_ack.

Reset
REQ-036 When rst_n=0 at a rising edge:
  - state <= ACTIVE;
  - R.valid and all R fields <= 0;
  - ReadData_out <= 0;
  - wait counter <= 0;
  - mem_err <= 0.
REQ-037 During reset all outputs SHALL read 0, including mem_req, stall_out and wb_valid.
REQ-038 Reset asserted in MEMWAIT aborts the access: mem_req=0 from the next cycle, and no wb_valid is produced for the aborted instruction.

Verification
REQ-039 ALU op: ex_valid=1, RegWrite=1, ALU_Result=16'h1234 -> next cycle wb_valid=1, RegWrite_out=1, ALU_Result_out=16'h1234, stall_out=0.
REQ-040 Load: MemRead=1, addr 16'h0040, mem_ack after 3 wait cycles with mem_rdata=16'hBEEF.
  - stall_out=1 and mem_req=1 for 3 cycles;
  - then wb_valid=1 and ReadData_out=16'hBEEF.
REQ-041 Store then load back-to-back -> two separate requests: mem_we=1 then mem_we=0, each with its own stall window.
REQ-042 flush=1 with ex_valid=1 -> wb_valid=0, RegWrite_out=0, mem_req never asserted.
REQ-043 Load with no mem_ack -> after 15 cycles mem_err=1, RegWrite_out=0 and ReadData_out=0 on completion; mem_err stays 1 until rst_n=0.
REQ-044 rst_n=0 during MEMWAIT -> next cycle mem_req=0, stall_out=0, wb_valid=0, and all outputs are 0.

Source files
------------

// File: rtl/exm_mem_stage.sv
// -----------------------------------------------------------------------------
// exm_mem_stage
//
// EX/MEM pipeline register with a blocking data-memory access stage.
//
// The stage captures one instruction from EX whenever it is not stalling. An
// instruction that reads or writes memory parks the stage in MEMWAIT. It holds
// the request there until mem_ack arrives or a 15-cycle timeout expires. The
// instruction is then presented to MWBBuffer with wb_valid for one cycle. A
// non-memory instruction is presented the cycle after capture.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   ex_valid, flush            EX instruction valid / kill on capture
//   MemRead_in .. RegWrite_in  EX control bits
//   ALU_Result_in              EX result, doubles as memory address
//   WriteData_in               store data
//   movOP_in                   move-op code, passed through
//   IDEX_RS, IDEX_RT           source register numbers for forwarding
//   mem_req, mem_we            memory request / write enable
//   mem_addr, mem_wdata        memory address / store data
//   mem_rdata, mem_ack         read data, valid with one-cycle ack
//   stall_out                  upstream must hold EX inputs while high
//   wb_valid                   write-back outputs carry a finished instruction
//   MemToReg_out, RegWrite_out control bits to MWBBuffer
//   ALU_Result_out             registered ALU result
//   ReadData_out               load data (0 for stores and timeouts)
//   movOP_out                  registered move-op code
//   EXM_RS, EXM_RT             forwarding register numbers
//   mem_err                    sticky memory-timeout flag
// -----------------------------------------------------------------------------
module exm_mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        flush,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        MemToReg_in,
  input  logic        RegWrite_in,
  input  logic [15:0] ALU_Result_in,
  input  logic [15:0] WriteData_in,
  input  logic [3:0]  movOP_in,
  input  logic [3:0]  IDEX_RS,
  input  logic [3:0]  IDEX_RT,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_out,
  output logic        wb_valid,
  output logic        MemToReg_out,
  output logic        RegWrite_out,
  output logic [15:0] ALU_Result_out,
  output logic [15:0] ReadData_out,
  output logic [3:0]  movOP_out,
  output logic [3:0]  EXM_RS,
  output logic [3:0]  EXM_RT,
  output logic        mem_err
);

  typedef enum logic [0:0] {
    StActive  = 1'b0,
    StMemWait = 1'b1
  } state_e;

  // Value of the wait counter during the 15th MEMWAIT cycle.
  localparam logic [3:0] LastWaitCnt = 4'd14;

  state_e      r_state;
  state_e      w_state_nxt;

  // EX/MEM register R
  logic        r_valid;
  logic        r_mem_read;
  logic        r_mem_write;
  logic        r_mem_to_reg;
  logic        r_reg_write;
  logic [15:0] r_alu_result;
  logic [15:0] r_write_data;
  logic [3:0]  r_mov_op;
  logic [3:0]  r_rs;
  logic [3:0]  r_rt;

  logic [15:0] r_read_data;
  logic [3:0]  r_wait_cnt;
  logic        r_mem_err;
  // Set when the held instruction completed by timeout; suppresses its RegWrite.
  logic        r_timed_out;

  logic        w_cap_valid;
  logic        w_cap_mem;
  logic        w_timeout;
  logic        w_active;
  logic        w_wait;

  assign w_cap_valid = ex_valid & ~flush;
  assign w_cap_mem   = w_cap_valid & (MemRead_in | MemWrite_in);
  // An ack in the last wait cycle wins over the timeout.
  assign w_timeout   = (r_state == StMemWait) & ~mem_ack & (r_wait_cnt == LastWaitCnt);

  // Outputs are forced to zero while reset is low, not just after the edge.
  assign w_active    = rst_n & (r_state == StActive);
  assign w_wait      = rst_n & (r_state == StMemWait);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StActive: begin
        if (w_cap_mem) begin
          w_state_nxt = StMemWait;
        end
      end
      StMemWait: begin
        if (mem_ack || w_timeout) begin
          w_state_nxt = StActive;
        end
      end
      default: w_state_nxt = StActive;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and EX/MEM register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= StActive;
      r_valid      <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_reg_write  <= 1'b0;
      r_alu_result <= 16'h0000;
      r_write_data <= 16'h0000;
      r_mov_op     <= 4'h0;
      r_rs         <= 4'h0;
      r_rt         <= 4'h0;
      r_read_data  <= 16'h0000;
      r_wait_cnt   <= 4'd0;
      r_mem_err    <= 1'b0;
      r_timed_out  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == StActive) begin
        // stall_out is low: capture EX. flush only matters on this path.
        r_valid      <= w_cap_valid;
        r_mem_read   <= MemRead_in;
        r_mem_write  <= MemWrite_in;
        r_mem_to_reg <= MemToReg_in;
        r_reg_write  <= RegWrite_in;
        r_alu_result <= ALU_Result_in;
        r_write_data <= WriteData_in;
        r_mov_op     <= movOP_in;
        r_rs         <= IDEX_RS;
        r_rt         <= IDEX_RT;
        r_timed_out  <= 1'b0;
        // MEMWAIT is only entered from here, so this clears on every entry.
        r_wait_cnt   <= 4'd0;
      end else begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
        if (mem_ack) begin
          r_read_data <= r_mem_read ? mem_rdata : 16'h0000;
        end else if (w_timeout) begin
          r_read_data <= 16'h0000;
          r_mem_err   <= 1'b1;
          r_timed_out <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_req        = w_wait;
    stall_out      = w_wait;
    mem_we         = w_wait & r_mem_write;
    mem_addr       = w_wait ? r_alu_result : 16'h0000;
    mem_wdata      = w_wait ? r_write_data : 16'h0000;
    wb_valid       = w_active & r_valid;
    RegWrite_out   = w_active & r_valid & r_reg_write & ~r_timed_out;
    MemToReg_out   = rst_n & r_mem_to_reg;
    ALU_Result_out = rst_n ? r_alu_result : 16'h0000;
    ReadData_out   = rst_n ? r_read_data : 16'h0000;
    movOP_out      = rst_n ? r_mov_op : 4'h0;
    EXM_RS         = rst_n ? r_rs : 4'h0;
    EXM_RT         = rst_n ? r_rt : 4'h0;
    mem_err        = rst_n & r_mem_err;
  end

endmodule

// File: tb/tb_exm_mem_stage.sv
module tb_exm_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, flush;
  logic        MemRead_in, MemWrite_in, MemToReg_in, RegWrite_in;
  logic [15:0] ALU_Result_in, WriteData_in;
  logic [3:0]  movOP_in, IDEX_RS, IDEX_RT;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        stall_out, wb_valid, MemToReg_out, RegWrite_out;
  logic [15:0] ALU_Result_out, ReadData_out;
  logic [3:0]  movOP_out, EXM_RS, EXM_RT;
  logic        mem_err;

  exm_mem_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .flush          (flush),
    .MemRead_in     (MemRead_in),
    .MemWrite_in    (MemWrite_in),
    .MemToReg_in    (MemToReg_in),
    .RegWrite_in    (RegWrite_in),
    .ALU_Result_in  (ALU_Result_in),
    .WriteData_in   (WriteData_in),
    .movOP_in       (movOP_in),
    .IDEX_RS        (IDEX_RS),
    .IDEX_RT        (IDEX_RT),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack),
    .stall_out      (stall_out),
    .wb_valid       (wb_valid),
    .MemToReg_out   (MemToReg_out),
    .RegWrite_out   (RegWrite_out),
    .ALU_Result_out (ALU_Result_out),
    .ReadData_out   (ReadData_out),
    .movOP_out      (movOP_out),
    .EXM_RS         (EXM_RS),
    .EXM_RT         (EXM_RT),
    .mem_err        (mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v, fl, mr, mw, m2r, rw;
    logic [15:0] alu, wd;
    logic [3:0]  mov, rs, rt;
    int          dly;      // ack in this request cycle; 0 = never ack
    logic [15:0] rdata;
    logic        exp_wb, exp_mem, exp_rw;
    logic [15:0] exp_rd;
    logic        chk_rd;
  } vec_t;

  typedef struct {
    logic        rw, m2r;
    logic [15:0] alu, rd;
    logic        chk_rd;
    logic [3:0]  mov, rs, rt;
  } wb_t;

  typedef struct {
    logic        we;
    logic [15:0] addr, wdata;
    int          dly;
    logic [15:0] rdata;
  } acc_t;

  int   total = 0;
  int   bad = 0;
  wb_t  wb_q[$];
  acc_t acc_q[$];
  acc_t cur;
  int   req_cnt = 0;
  logic exp_err = 1'b0;
  logic auto_chk = 1'b0;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic v, fl, mr, mw, m2r, rw,
                              input logic [15:0] alu, wd, input logic [3:0] mov, rs, rt,
                              input int dly, input logic [15:0] rdata,
                              input logic exp_wb, exp_mem, exp_rw,
                              input logic [15:0] exp_rd, input logic chk_rd);
    vec_t t;
    t.v = v; t.fl = fl; t.mr = mr; t.mw = mw; t.m2r = m2r; t.rw = rw;
    t.alu = alu; t.wd = wd; t.mov = mov; t.rs = rs; t.rt = rt;
    t.dly = dly; t.rdata = rdata;
    t.exp_wb = exp_wb; t.exp_mem = exp_mem; t.exp_rw = exp_rw;
    t.exp_rd = exp_rd; t.chk_rd = chk_rd;
    return t;
  endfunction

  // Memory responder plus output monitor, all on the falling edge.
  always @(negedge clk) begin
    if (!auto_chk) begin
      mem_ack = 1'b0;
    end else begin
      if (mem_req) begin
        if (req_cnt == 0) begin
          if (acc_q.size() == 0) begin
            chk("spurious_req", 32'(mem_req), 32'd0);
            cur = '{we: 1'b0, addr: 16'h0, wdata: 16'h0, dly: 1, rdata: 16'h0};
          end else begin
            cur = acc_q.pop_front();
            chk("mem_we", 32'(mem_we), 32'(cur.we));
            chk("mem_addr", 32'(mem_addr), 32'(cur.addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(cur.wdata));
          end
        end
        req_cnt++;
        if (req_cnt == 16) chk("req_overrun", 32'(req_cnt), 32'd15);
        if (cur.dly != 0 && req_cnt == cur.dly) begin
          mem_ack   = 1'b1;
          mem_rdata = cur.rdata;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 16'($urandom);
        end
      end else begin
        if (req_cnt != 0) begin
          chk("stall_window", 32'(req_cnt), (cur.dly == 0) ? 32'd15 : 32'(cur.dly));
          if (cur.dly == 0) exp_err = 1'b1;
          req_cnt = 0;
        end
        // Stray acks while idle must be ignored.
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = 16'($urandom);
      end

      chk("stall_eq_req", 32'(stall_out), 32'(mem_req));
      chk("mem_err", 32'(mem_err), 32'(exp_err));
      if (wb_valid) begin
        chk("wb_not_stalled", 32'(stall_out), 32'd0);
        if (wb_q.size() == 0) begin
          chk("spurious_wb", 32'(wb_valid), 32'd0);
        end else begin
          wb_t e;
          e = wb_q.pop_front();
          chk("RegWrite_out", 32'(RegWrite_out), 32'(e.rw));
          chk("MemToReg_out", 32'(MemToReg_out), 32'(e.m2r));
          chk("ALU_Result_out", 32'(ALU_Result_out), 32'(e.alu));
          chk("movOP_out", 32'(movOP_out), 32'(e.mov));
          chk("EXM_RS", 32'(EXM_RS), 32'(e.rs));
          chk("EXM_RT", 32'(EXM_RT), 32'(e.rt));
          if (e.chk_rd) chk("ReadData_out", 32'(ReadData_out), 32'(e.rd));
        end
      end else begin
        chk("rw_gated", 32'(RegWrite_out), 32'd0);
      end
    end
  end

  initial begin
    logic st, captured;
    int   cnt;
    rst_n = 1'b0; ex_valid = 1'b0; flush = 1'b0;
    MemRead_in = 1'b0; MemWrite_in = 1'b0; MemToReg_in = 1'b0; RegWrite_in = 1'b0;
    ALU_Result_in = 16'h0; WriteData_in = 16'h0;
    movOP_in = 4'h0; IDEX_RS = 4'h0; IDEX_RT = 4'h0;
    mem_ack = 1'b0; mem_rdata = 16'h0;

    //          v  fl mr mw m2r rw alu       wd        mov   rs    rt    dly rdata
    //          wb mem rw exp_rd   chk_rd
    vecs[0] = mk(1, 0, 0, 0, 0, 1, 16'h1234, 16'h0000, 4'h3, 4'h1, 4'h2, 0, 16'h0000,
                 1, 0, 1, 16'h0000, 0);
    vecs[1] = mk(1, 0, 1, 0, 1, 1, 16'h0040, 16'h0000, 4'h0, 4'h4, 4'h5, 3, 16'hBEEF,
                 1, 1, 1, 16'hBEEF, 1);
    vecs[2] = mk(1, 0, 0, 1, 0, 0, 16'h0080, 16'hCAFE, 4'h0, 4'h6, 4'h7, 2, 16'hDEAD,
                 1, 1, 0, 16'h0000, 1);
    vecs[3] = mk(1, 0, 1, 0, 1, 1, 16'h0082, 16'h0000, 4'h0, 4'h8, 4'h9, 1, 16'h1111,
                 1, 1, 1, 16'h1111, 1);
    // Flush is held during the previous load's wait and must only kill this one.
    vecs[4] = mk(1, 1, 1, 0, 1, 1, 16'h0090, 16'h0000, 4'h0, 4'hA, 4'hB, 1, 16'h2222,
                 0, 0, 0, 16'h0000, 0);
    vecs[5] = mk(0, 0, 0, 0, 0, 1, 16'h9999, 16'h0000, 4'h0, 4'h0, 4'h0, 0, 16'h0000,
                 0, 0, 0, 16'h0000, 0);
    vecs[6] = mk(1, 0, 0, 0, 0, 1, 16'h5555, 16'h0000, 4'hC, 4'hD, 4'hE, 0, 16'h0000,
                 1, 0, 1, 16'h0000, 0);
    // Ack in the 15th wait cycle: ack wins, no error.
    vecs[7] = mk(1, 0, 1, 0, 1, 1, 16'h00A0, 16'h0000, 4'h1, 4'h2, 4'h3, 15, 16'h7777,
                 1, 1, 1, 16'h7777, 1);
    // No ack: timeout, RegWrite suppressed, data zero.
    vecs[8] = mk(1, 0, 1, 0, 1, 1, 16'h00B0, 16'h0000, 4'h4, 4'h5, 4'h6, 0, 16'h0000,
                 1, 1, 0, 16'h0000, 1);
    vecs[9] = mk(1, 0, 0, 0, 0, 1, 16'hABCD, 16'h0000, 4'h7, 4'h8, 4'h9, 0, 16'h0000,
                 1, 0, 1, 16'h0000, 0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_all_outs", 32'(|{mem_req, mem_we, mem_addr, mem_wdata, stall_out, wb_valid,
                              MemToReg_out, RegWrite_out, ALU_Result_out, ReadData_out,
                              movOP_out, EXM_RS, EXM_RT, mem_err}), 32'd0);
    rst_n    = 1'b1;
    auto_chk = 1'b1;

    // Table-driven stream; inputs held while stall_out is high.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ex_valid = vecs[i].v; flush = vecs[i].fl;
      MemRead_in = vecs[i].mr; MemWrite_in = vecs[i].mw;
      MemToReg_in = vecs[i].m2r; RegWrite_in = vecs[i].rw;
      ALU_Result_in = vecs[i].alu; WriteData_in = vecs[i].wd;
      movOP_in = vecs[i].mov; IDEX_RS = vecs[i].rs; IDEX_RT = vecs[i].rt;
      captured = 1'b0;
      cnt = 0;
      while (!captured && cnt < 64) begin
        st = stall_out;
        @(posedge clk);
        if (!st) captured = 1'b1;
        else begin
          @(negedge clk);
          cnt++;
        end
      end
      if (!captured) chk("capture_timeout", 32'(captured), 32'd1);
      if (vecs[i].exp_wb)
        wb_q.push_back('{rw: vecs[i].exp_rw, m2r: vecs[i].m2r, alu: vecs[i].alu,
                         rd: vecs[i].exp_rd, chk_rd: vecs[i].chk_rd, mov: vecs[i].mov,
                         rs: vecs[i].rs, rt: vecs[i].rt});
      if (vecs[i].exp_mem)
        acc_q.push_back('{we: vecs[i].mw, addr: vecs[i].alu, wdata: vecs[i].wd,
                          dly: vecs[i].dly, rdata: vecs[i].rdata});
    end
    @(negedge clk);
    ex_valid = 1'b0; flush = 1'b0; MemRead_in = 1'b0; MemWrite_in = 1'b0;

    for (int k = 0; k < 100; k++) begin
      if (wb_q.size() == 0 && acc_q.size() == 0 && !mem_req && req_cnt == 0) break;
      @(negedge clk);
    end
    chk("drain", 32'(wb_q.size() + acc_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    chk("mem_err_sticky", 32'(mem_err), 32'd1);

    // Reset asserted while a load waits for its ack.
    auto_chk = 1'b0;
    @(negedge clk);
    ex_valid = 1'b1; MemRead_in = 1'b1; MemToReg_in = 1'b1; RegWrite_in = 1'b1;
    ALU_Result_in = 16'h0100;
    @(posedge clk);
    @(negedge clk);
    ex_valid = 1'b0; MemRead_in = 1'b0;
    chk("abort_req_pre", 32'(mem_req), 32'd1);
    chk("abort_stall_pre", 32'(stall_out), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_mem_req", 32'(mem_req), 32'd0);
    chk("abort_stall", 32'(stall_out), 32'd0);
    chk("abort_wb_valid", 32'(wb_valid), 32'd0);
    chk("abort_all_outs", 32'(|{mem_req, mem_we, mem_addr, mem_wdata, stall_out, wb_valid,
                                MemToReg_out, RegWrite_out, ALU_Result_out, ReadData_out,
                                movOP_out, EXM_RS, EXM_RT, mem_err}), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_quiet_wb", 32'(wb_valid), 32'd0);
      chk("abort_quiet_req", 32'(mem_req), 32'd0);
    end
    chk("err_cleared", 32'(mem_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
